ddr3_burst_arb: RTL
===================

# ddr3_burst_arb

Burst-level arbiter sharing one MIG user port between two write requesters (e.g. two camera channels) and one read requester (display path). Sits between the channel FIFOs and the MIG IP. Monitors FIFO fill levels, grants whole bursts, and generates per-channel frame addresses with wrap and frame-start reset. Drives the MIG app command and write-data handshake.

## Interface
- DATA_W, 128, MIG app data width
- BURST_LEN, 64, beats per granted burst (1..255)
- FRAME_SIZE, 28'd1_048_576, address span of one frame; multiple of 8*BURST_LEN
- WR0_BASE, 28'h000_0000, region base for write channel 0
- WR1_BASE, 28'h040_0000, region base for write channel 1
- RD_THRESH, 11'd512, read requests when rfifo_wcount <= RD_THRESH

Ports:
- ui_clk  in  1  MIG user clock
- rst_n  in  1  asynchronous reset, active-low
- init_calib_complete  in  1  MIG calibration done
- app_rdy / app_wdf_rdy  in  1 / 1  MIG command ready / write-FIFO ready
- app_rd_data_valid  in  1  MIG read data valid
- wr0_count / wr1_count  in  11 each  write-FIFO read counts
- wr0_data / wr1_data  in  DATA_W each  FWFT write-FIFO heads
- wr0_load / wr1_load  in  1 each  frame-start, asynchronous level
- rfifo_wcount  in  11  read-FIFO write count
- rd_load  in  1  display frame-start, asynchronous level
- rd_en  in  1  read enable
- rd_sel  in  1  source region for reads; latched at rd_load edge
- wr0_ren / wr1_ren  out  1 each  write-FIFO pop
- rfifo_wren  out  1  = app_rd_data_valid
- app_addr  out  28  MIG address
- app_cmd  out  3  0 write, 1 read
- app_en / app_wdf_wren / app_wdf_end  out  1 each
- app_wdf_data  out  DATA_W  muxed write data

## Operation
- States: IDLE, ARB, WRITE, READ.
- IDLE -> ARB when init_calib_complete = 1.
- Load inputs: 2-flop synchronised, rising-edge detected.
- A detected edge sets that channel's pending-reset flag.
- Pending-reset flags apply in ARB only, never mid-burst:
  - write channel: offset <= 0;
  - read: offset <= 0 and rd_sel latched.
- Candidates in ARB:
  - RD: rd_en && rfifo_wcount <= RD_THRESH.
  - W0: wr0_count >= BURST_LEN.
  - W1: wr1_count >= BURST_LEN.
- Priority: RD first (underrun avoidance), then writes per Configuration.
- The winning grant is registered; the FSM enters WRITE or READ with beat counter = 0.
- No candidate: stay in ARB.
- WRITE:
  - beat accepted iff app_rdy && app_wdf_rdy;
  - app_en = app_wdf_wren = app_wdf_end = beat accepted (4:1 mode, one beat per command);
  - granted channel's wrN_ren = beat accepted.
- READ: beat accepted iff app_rdy; app_en = app_rdy.
- On each accepted beat:
  - beat counter +1;
  - channel offset += 8;
  - if offset + 8 == FRAME_SIZE, offset wraps to 0.
- Beat BURST_LEN-1 accepted -> ARB.
- app_addr:
  - write grant: WRN_BASE + offset of the granted write channel;
  - read grant: (rd_sel_latched ? WR1_BASE : WR0_BASE) + rd offset.
- app_cmd = 1 only in READ; otherwise 0.
- app_wdf_data = granted channel's data; wr0_data when no write grant.
- Arithmetic: offsets 28-bit unsigned; bases plus offsets never exceed 28 bits.

## Timing
- Reset values:
  - app_en, app_wdf_wren, app_wdf_end, wr0_ren, wr1_ren, app_cmd = 0;
  - app_addr = WR0_BASE;
  - all offsets 0, state IDLE.
- app_en, app_wdf_wren, wrN_ren, rfifo_wren: combinational from state and MIG ready, no added latency.
- ARB decision to first app_en: 1 cycle.
- Burst end to next ARB decision: 1 idle cycle.
- Load edge to pending flag: 3 cycles.
- Load edge during a burst: burst completes at old offset; reset applies at next ARB.
- Simultaneous load edge and a wrap on the same beat: the load wins at next ARB.
- Ready deassert mid-burst: counters and address hold; no beat lost or duplicated.
- rst_n asserted mid-burst: immediate return to reset values; partial burst abandoned.

## Configuration
- ARB_RR_EN defined:
  - W0/W1 tie broken round-robin;
  - last-served write channel loses the next tie;
  - the pointer updates only on a write grant.
- ARB_RR_EN undefined: fixed priority, W0 over W1.

## Test plan
- Calib held low 100 cycles, wr0_count=64 -> no app_en. Calib high -> WRITE burst of exactly 64 app_en pulses at addresses 0, 8, ..., 504.
- rfifo_wcount=100, rd_en=1, wr0_count=64 together -> READ granted first, app_cmd=1, 64 beats, then WRITE burst.
- Both write counts >=64 for 4 bursts:
  - ARB_RR_EN: grants W0, W1, W0, W1;
  - without ARB_RR_EN: W0 ×4.
- app_rdy toggled randomly during WRITE -> exactly 64 wr0_ren, addresses contiguous, none skipped.
- FRAME_SIZE=1024, BURST_LEN=64, 2 bursts on W1 -> second burst ends at WR1_BASE+1016; next burst starts at WR1_BASE.
- wr0_load edge mid-burst at beat 20 -> burst finishes to beat 63; next W0 burst starts at WR0_BASE.

Source files
------------

// File: rtl/ddr3_burst_arb.sv
// Burst arbiter sharing one MIG user port between two write channels and one read channel.
// Optional macro ARB_RR_EN: round-robin W0/W1 tie-break (default build: W0 beats W1).
module ddr3_burst_arb #(
  parameter int          DATA_W     = 128,
  parameter int          BURST_LEN  = 64,
  parameter logic [27:0] FRAME_SIZE = 28'd1_048_576,
  parameter logic [27:0] WR0_BASE   = 28'h000_0000,
  parameter logic [27:0] WR1_BASE   = 28'h040_0000,
  parameter logic [10:0] RD_THRESH  = 11'd512
) (
  input  logic              ui_clk,
  input  logic              rst_n,
  input  logic              init_calib_complete,
  input  logic              app_rdy,
  input  logic              app_wdf_rdy,
  input  logic              app_rd_data_valid,
  input  logic [10:0]       wr0_count,
  input  logic [10:0]       wr1_count,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic              wr0_load,
  input  logic              wr1_load,
  input  logic [10:0]       rfifo_wcount,
  input  logic              rd_load,
  input  logic              rd_en,
  input  logic              rd_sel,
  output logic              wr0_ren,
  output logic              wr1_ren,
  output logic              rfifo_wren,
  output logic [27:0]       app_addr,
  output logic [2:0]        app_cmd,
  output logic              app_en,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  output logic [DATA_W-1:0] app_wdf_data
);

  typedef enum logic [1:0] {IDLE, ARB, WRITE, READ} state_t;

  // Grant codes double as the offset index of the granted channel.
  localparam logic [1:0] G_W0 = 2'd0;
  localparam logic [1:0] G_W1 = 2'd1;
  localparam logic [1:0] G_RD = 2'd2;

  state_t      state_reg, state_next;
  logic [1:0]  grant_reg, grant_next;
  logic [7:0]  beat_cnt_reg;
  logic [27:0] offset_reg [3];
  logic [27:0] offset_inc [3];
  logic [2:0]  load_s1_reg, load_s2_reg, load_s3_reg, pend_reg;
  logic [2:0]  load_edge;
  logic        rd_sel_lat_reg;
  logic        rd_cand, w0_cand, w1_cand, tie_w1, beat_ok, last_beat;

  assign load_edge  = load_s2_reg & ~load_s3_reg;
  assign rd_cand    = rd_en && (rfifo_wcount <= RD_THRESH);
  assign w0_cand    = wr0_count >= 11'(BURST_LEN);
  assign w1_cand    = wr1_count >= 11'(BURST_LEN);
  assign beat_ok    = (state_reg == WRITE) ? (app_rdy && app_wdf_rdy) :
                      (state_reg == READ)  ? app_rdy : 1'b0;
  assign last_beat  = beat_ok && (beat_cnt_reg == 8'(BURST_LEN - 1));
  assign rfifo_wren = app_rd_data_valid;

  always_comb begin
    for (int i = 0; i < 3; i++)
      offset_inc[i] = (offset_reg[i] + 28'd8 == FRAME_SIZE) ? 28'd0 : offset_reg[i] + 28'd8;
  end

`ifdef ARB_RR_EN
  logic rr_last_w0_reg;
  assign tie_w1 = rr_last_w0_reg;

  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n)
      rr_last_w0_reg <= 1'b0;
    else if (state_reg == ARB && state_next == WRITE)
      rr_last_w0_reg <= (grant_next == G_W0);
  end
`else
  assign tie_w1 = 1'b0;
`endif

  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      grant_reg <= G_W0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    app_en       = 1'b0;
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
    wr0_ren      = 1'b0;
    wr1_ren      = 1'b0;
    app_cmd      = 3'd0;
    app_addr     = WR0_BASE;
    app_wdf_data = wr0_data;
    case (state_reg)
      IDLE: if (init_calib_complete) state_next = ARB;
      ARB: begin
        // Reads first to keep the display FIFO from underrunning.
        if (rd_cand) begin
          grant_next = G_RD;
          state_next = READ;
        end else if (w0_cand && !(w1_cand && tie_w1)) begin
          grant_next = G_W0;
          state_next = WRITE;
        end else if (w1_cand) begin
          grant_next = G_W1;
          state_next = WRITE;
        end
      end
      WRITE: begin
        app_en       = beat_ok;
        app_wdf_wren = beat_ok;
        app_wdf_end  = beat_ok;
        wr0_ren      = beat_ok && (grant_reg == G_W0);
        wr1_ren      = beat_ok && (grant_reg == G_W1);
        if (grant_reg == G_W1) begin
          app_addr     = WR1_BASE + offset_reg[1];
          app_wdf_data = wr1_data;
        end else begin
          app_addr = WR0_BASE + offset_reg[0];
        end
        if (last_beat) state_next = ARB;
      end
      READ: begin
        app_en   = app_rdy;
        app_cmd  = 3'd1;
        app_addr = (rd_sel_lat_reg ? WR1_BASE : WR0_BASE) + offset_reg[2];
        if (last_beat) state_next = ARB;
      end
      default: state_next = IDLE;
    endcase
  end

  // Frame-start requests are parked until ARB so a burst never changes address mid-way.
  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      load_s1_reg    <= '0;
      load_s2_reg    <= '0;
      load_s3_reg    <= '0;
      pend_reg       <= '0;
      beat_cnt_reg   <= '0;
      rd_sel_lat_reg <= 1'b0;
      for (int i = 0; i < 3; i++) offset_reg[i] <= '0;
    end else begin
      load_s1_reg <= {rd_load, wr1_load, wr0_load};
      load_s2_reg <= load_s1_reg;
      load_s3_reg <= load_s2_reg;
      pend_reg    <= (state_reg == ARB) ? load_edge : (pend_reg | load_edge);
      if (state_reg == ARB)
        beat_cnt_reg <= '0;
      else if (beat_ok)
        beat_cnt_reg <= beat_cnt_reg + 8'd1;
      if (state_reg == ARB && pend_reg[2])
        rd_sel_lat_reg <= rd_sel;
      for (int i = 0; i < 3; i++) begin
        if (state_reg == ARB && pend_reg[i])
          offset_reg[i] <= '0;
        else if (beat_ok && grant_reg == 2'(i))
          offset_reg[i] <= offset_inc[i];
      end
    end
  end

endmodule
